// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hold controller.
// Stall vector bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB.
package pipe_stall_ctrl_pkg;

    localparam int CNT_W_DEF = 5;
    localparam int STALL_PC  = 0;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating enable counter; holds at all-ones instead of wrapping.
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hold controller: merges ID hazards, multi-cycle EX ops and flushes
// into one stall vector, and sequences the EX step counter.
//   state      | meaning
//   ST_IDLE    | no multi-cycle op, front end free unless ID hazard
//   ST_MC_BUSY | multi-cycle op running, mc_cnt_o is the current step
//   ST_FLUSH   | one-cycle flush strobe to IF/ID and ID/EX
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STALL_W = 6,
    parameter int PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               mc_start,
    input  logic [CNT_W-1:0]   mc_len,
    input  logic               flush_req,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic [CNT_W-1:0]   mc_cnt_o,
    output logic               mc_last_o,
    output logic               busy_o,
    output logic [PERF_W-1:0]  stall_cyc_o
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [CNT_W-1:0] len_q, len_nxt;
    logic             mc_accept;
    logic             mc_last;
    logic [5:0]       stall_vec;

    // Lengths 0 and 1 complete in a single EX cycle and never enter MC_BUSY.
    assign mc_accept = mc_start && (mc_len >= CNT_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            len_q <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        len_nxt   = len_q;
        mc_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_nxt = ST_FLUSH;
                end else if (mc_accept) begin
                    state_nxt = ST_MC_BUSY;
                    cnt_nxt   = CNT_W'(1);
                    len_nxt   = mc_len;
                end
            end
            ST_MC_BUSY: begin
                mc_last = (cnt_q == (len_q - CNT_W'(1)));
                if (flush_req) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = '0;
                end else if (mc_last) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: state_nxt = ST_IDLE;
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        stall_vec = STALL_NONE;
        if (rst || (state == ST_FLUSH) || flush_req) begin
            stall_vec = STALL_NONE;
        end else if ((state == ST_MC_BUSY) && !mc_last) begin
            stall_vec = STALL_EX;
        end else if ((state == ST_IDLE) && mc_accept) begin
            stall_vec = STALL_EX;
        end else if (stallreq_id) begin
            stall_vec = STALL_ID;
        end
    end

    assign stall_o   = STALL_W'(stall_vec);
    assign flush_o   = (state == ST_FLUSH);
    assign mc_cnt_o  = cnt_q;
    assign mc_last_o = mc_last && !rst;
    assign busy_o    = (state != ST_IDLE) && !rst;

    pipe_perf_cnt #(.W(PERF_W)) u_perf (
        .clk (clk),
        .rst (rst),
        .en  (stall_vec[STALL_PC] && !rst),
        .cnt (stall_cyc_o)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

    localparam int CNT_W    = 5;
    localparam int STALL_W  = 6;
    localparam int PERF_W   = 6;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    typedef struct packed {
        logic [5:0]       stall;
        logic             flush;
        logic [CNT_W-1:0] cnt;
        logic             last;
        logic             busy;
        logic [PERF_W-1:0] perf;
    } obs_t;

    logic               clk;
    logic               rst;
    logic               stallreq_id;
    logic               mc_start;
    logic [CNT_W-1:0]   mc_len;
    logic               flush_req;
    logic [STALL_W-1:0] stall_o;
    logic               flush_o;
    logic [CNT_W-1:0]   mc_cnt_o;
    logic               mc_last_o;
    logic               busy_o;
    logic [PERF_W-1:0]  stall_cyc_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: an op in progress at step m_step of m_len, or a pending flush.
    bit m_op    = 0;
    bit m_flush = 0;
    int m_step  = 0;
    int m_len   = 0;
    int m_perf  = 0;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .STALL_W(STALL_W), .PERF_W(PERF_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .mc_start    (mc_start),
        .mc_len      (mc_len),
        .flush_req   (flush_req),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .mc_cnt_o    (mc_cnt_o),
        .mc_last_o   (mc_last_o),
        .busy_o      (busy_o),
        .stall_cyc_o (stall_cyc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t model_out(bit r, bit sreq, bit mcs, int len, bit fr);
        obs_t e;
        bit   acc;
        e.flush = m_flush;
        e.cnt   = CNT_W'(m_step);
        e.perf  = PERF_W'(m_perf);
        e.busy  = (m_op || m_flush) && !r;
        e.last  = m_op && (m_step == m_len - 1) && !r;
        acc     = !m_op && !m_flush && mcs && (len >= 2);
        if (r || m_flush || fr)         e.stall = 6'b000000;
        else if (m_op && !e.last)       e.stall = 6'b001111;
        else if (acc)                   e.stall = 6'b001111;
        else if (sreq)                  e.stall = 6'b000111;
        else                            e.stall = 6'b000000;
        return e;
    endfunction

    function automatic void model_step(bit r, bit mcs, int len, bit fr, obs_t e);
        if (r) begin
            m_op = 0; m_flush = 0; m_step = 0; m_perf = 0;
            return;
        end
        if (e.stall[0] && m_perf < PERF_MAX) m_perf++;
        if (m_flush) m_flush = 0;
        else if (fr) begin
            m_flush = 1; m_op = 0; m_step = 0;
        end else if (m_op) begin
            if (e.last) begin m_op = 0; m_step = 0; end
            else m_step++;
        end else if (mcs && len >= 2) begin
            m_op = 1; m_step = 1; m_len = len;
        end
    endfunction

    task automatic run_cycle(input bit r, input bit sreq, input bit mcs, input int len,
                             input bit fr, output obs_t got, output obs_t exp);
        @(negedge clk);
        rst = r; stallreq_id = sreq; mc_start = mcs; mc_len = CNT_W'(len); flush_req = fr;
        #1;
        got = {stall_o, flush_o, mc_cnt_o, mc_last_o, busy_o, stall_cyc_o};
        exp = model_out(r, sreq, mcs, len, fr);
        @(posedge clk);
        model_step(r, mcs, len, fr, exp);
    endtask

    task automatic test_reset();
        obs_t got, exp;
        run_cycle(1, 1, 1, 31, 1, got, exp);
        run_cycle(1, 1, 1, 31, 1, got, exp);
        n_chk++;
        if (got !== 20'h0) begin
            n_fail++;
            $display("FAIL reset: got %h exp %h", got, 20'h0);
        end
    endtask

    task automatic test_id_stall();
        obs_t got, exp;
        logic [5:0] want [2] = '{6'b000111, 6'b000000};
        for (int i = 0; i < 2; i++) begin
            run_cycle(0, (i == 0), 0, 0, 0, got, exp);
            n_chk++;
            if (got.stall !== want[i] || got.busy !== 1'b0 || got !== exp) begin
                n_fail++;
                $display("FAIL id_stall c%0d: got %h exp %h stall want %b", i, got, exp, want[i]);
            end
        end
    endtask

    task automatic test_mc_op();
        obs_t got, exp;
        logic [5:0] w_stall [5] = '{6'b001111, 6'b001111, 6'b001111, 6'b000000, 6'b000000};
        int         w_cnt   [5] = '{0, 1, 2, 3, 0};
        bit         w_last  [5] = '{0, 0, 0, 1, 0};
        int         perf0;
        run_cycle(1, 0, 0, 0, 0, got, exp);
        perf0 = m_perf;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 0, (i == 0), 4, 0, got, exp);
            n_chk++;
            if (got.stall !== w_stall[i] || got.cnt !== CNT_W'(w_cnt[i]) ||
                got.last !== w_last[i] || got !== exp) begin
                n_fail++;
                $display("FAIL mc_op c%0d: got %h exp %h", i, got, exp);
            end
        end
        n_chk++;
        if (got.perf !== PERF_W'(perf0 + 3) || got.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_op_perf: got %0d busy %b exp %0d busy 0", got.perf, got.busy, perf0 + 3);
        end
    endtask

    task automatic test_short_ops();
        obs_t got, exp;
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 0, (i % 2 == 0), (i < 2) ? 1 : 0, 0, got, exp);
            n_chk++;
            if (got.stall !== 6'b0 || got.busy !== 1'b0 || got !== exp) begin
                n_fail++;
                $display("FAIL short_op c%0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_flush_mid_op();
        obs_t got, exp;
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 1, (i == 0), 6, (i == 1), got, exp);
            n_chk++;
            if (got !== exp ||
                (i == 1 && got.stall !== 6'b0) ||
                (i == 2 && (got.flush !== 1'b1 || got.stall !== 6'b0)) ||
                (i == 3 && (got.flush !== 1'b0 || got.cnt !== '0))) begin
                n_fail++;
                $display("FAIL flush_mid_op c%0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        bit   sreq, mcs, fr, r;
        int   len;
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 59) == 0);
            sreq = ($urandom_range(0, 2) == 0);
            fr   = ($urandom_range(0, 11) == 0);
            mcs  = !m_op && !m_flush && ($urandom_range(0, 3) == 0);
            len  = $urandom_range(0, 9);
            run_cycle(r, sreq, mcs, len, fr, got, exp);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random c%0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_saturation();
        obs_t got, exp;
        run_cycle(1, 0, 0, 0, 0, got, exp);
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < 31; i++) begin
                run_cycle(0, 0, (i == 0), 31, 0, got, exp);
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL saturation op%0d c%0d: got %h exp %h", op, i, got, exp);
                end
            end
        end
        run_cycle(0, 0, 0, 0, 0, got, exp);
        n_chk++;
        if (got.perf !== PERF_W'(PERF_MAX)) begin
            n_fail++;
            $display("FAIL saturation_final: got %0d exp %0d", got.perf, PERF_MAX);
        end
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b0; mc_start = 1'b0; mc_len = '0; flush_req = 1'b0;
        test_reset();
        test_id_stall();
        test_mc_op();
        test_short_ops();
        test_flush_mid_op();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
